// File: rtl/comprobador_sumador_pkg.sv
// Shared definitions for the exhaustive full-adder checker: vector space and FSM encoding.
package comprobador_sumador_pkg;

    localparam int VEC_W   = 3;
    localparam int NUM_VEC = 8;

    typedef logic [VEC_W-1:0] vec_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/sumador_completo.sv
// Reference full adder; the checker uses one instance as its golden model.
module sumador_completo (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);

    assign s_o    = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/comprobador_sumador.sv
// Exhaustive full-adder checker: walks all 8 input vectors, waits SETTLE_CYCLES,
// compares the response against a golden adder and reports error count / first failure.
module comprobador_sumador
    import comprobador_sumador_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       A,
    output logic       B,
    output logic       Cin,
    input  logic       S,
    input  logic       Cout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] fail_vec,
    output logic [2:0] vec_idx
);

    localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
    localparam vec_t       LAST_VEC    = vec_t'(NUM_VEC - 1);

    state_e     state_q;
    vec_t       vec_q;
    vec_t       fail_q;
    logic [3:0] settle_q;
    logic [3:0] err_q;
    logic [3:0] err_d;
    logic       a_q, b_q, cin_q;
    logic       busy_q, done_q, pass_q;
    logic       exp_s, exp_cout;
    logic       mismatch;

    // Golden model is fed from the internal vector register, not the output flops.
    sumador_completo u_gold (
        .a_i    (vec_q[2]),
        .b_i    (vec_q[1]),
        .cin_i  (vec_q[0]),
        .s_o    (exp_s),
        .cout_o (exp_cout)
    );

    assign mismatch = (S != exp_s) || (Cout != exp_cout);
    assign err_d    = err_q + {3'b000, mismatch};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            vec_q    <= '0;
            fail_q   <= '0;
            settle_q <= '0;
            err_q    <= '0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            cin_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q             <= ST_DRIVE;
                        vec_q               <= '0;
                        fail_q              <= '0;
                        err_q               <= '0;
                        {a_q, b_q, cin_q}   <= '0;
                        busy_q              <= 1'b1;
                        done_q              <= 1'b0;
                        pass_q              <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    settle_q <= '0;
                    state_q  <= (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_q == SETTLE_LAST) state_q <= ST_SAMPLE;
                    else                         settle_q <= settle_q + 4'd1;
                end
                ST_SAMPLE: begin
                    err_q <= err_d;
                    if (mismatch && err_q == 4'd0) fail_q <= vec_q;
                    if (vec_q == LAST_VEC) begin
                        // Final vector: park outputs at zero and publish the verdict.
                        state_q           <= ST_DONE;
                        {a_q, b_q, cin_q} <= '0;
                        busy_q            <= 1'b0;
                        done_q            <= 1'b1;
                        pass_q            <= (err_d == 4'd0);
                    end else begin
                        state_q           <= ST_DRIVE;
                        vec_q             <= vec_q + 3'd1;
                        {a_q, b_q, cin_q} <= vec_q + 3'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign Cin       = cin_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;
    assign vec_idx   = vec_q;

endmodule

// File: tb/tb_comprobador_sumador.sv
// Bench for comprobador_sumador: three instances (SETTLE 2/0/5) share stimulus and a faulty-adder responder.
module tb_comprobador_sumador;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] fault_mode;
    logic [7:0] mask;

    logic [2:0] a_w, b_w, cin_w, s_w, cout_w, busy_w, done_w, pass_w;
    logic [3:0] err_w  [3];
    logic [2:0] fail_w [3];
    logic [2:0] vidx_w [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Adder under test: 0 correct, 1 Cout stuck at 0, 2 S inverted, 3 S flipped on masked vectors.
    function automatic logic [1:0] adder_resp(input logic [2:0] v, input logic [1:0] m, input logic [7:0] mk);
        int   sum;
        logic s, c;
        sum = int'(v[2]) + int'(v[1]) + int'(v[0]);
        s   = (sum % 2) == 1;
        c   = sum >= 2;
        if (m == 2'd1) c = 1'b0;
        if (m == 2'd2) s = ~s;
        if (m == 2'd3) s = s ^ mk[v];
        return {c, s};
    endfunction

    function automatic int settle_of(input int d);
        return (d == 0) ? 2 : (d == 1) ? 0 : 5;
    endfunction

    assign {cout_w[0], s_w[0]} = adder_resp({a_w[0], b_w[0], cin_w[0]}, fault_mode, mask);
    assign {cout_w[1], s_w[1]} = adder_resp({a_w[1], b_w[1], cin_w[1]}, fault_mode, mask);
    assign {cout_w[2], s_w[2]} = adder_resp({a_w[2], b_w[2], cin_w[2]}, fault_mode, mask);

    comprobador_sumador #(.SETTLE_CYCLES(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a_w[0]), .B(b_w[0]), .Cin(cin_w[0]),
        .S(s_w[0]), .Cout(cout_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_count(err_w[0]), .fail_vec(fail_w[0]), .vec_idx(vidx_w[0]));
    comprobador_sumador #(.SETTLE_CYCLES(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a_w[1]), .B(b_w[1]), .Cin(cin_w[1]),
        .S(s_w[1]), .Cout(cout_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_count(err_w[1]), .fail_vec(fail_w[1]), .vec_idx(vidx_w[1]));
    comprobador_sumador #(.SETTLE_CYCLES(5)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a_w[2]), .B(b_w[2]), .Cin(cin_w[2]),
        .S(s_w[2]), .Cout(cout_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .err_count(err_w[2]), .fail_vec(fail_w[2]), .vec_idx(vidx_w[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: a correct full adder is sum = a+b+cin, S = sum mod 2, Cout = sum div 2.
    task automatic expect_run(input logic [1:0] m, input logic [7:0] mk, output int errs, output int first);
        errs  = 0;
        first = 0;
        for (int v = 0; v < 8; v++) begin
            int sum;
            logic [2:0] vv;
            vv  = 3'(v);
            sum = v / 4 + (v / 2) % 2 + v % 2;
            if (adder_resp(vv, m, mk) != {1'(sum / 2), 1'(sum % 2)}) begin
                if (errs == 0) first = v;
                errs++;
            end
        end
    endtask

    task automatic chk_idle_all(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_abc%0d", tag, d), {a_w[d], b_w[d], cin_w[d]}, 0);
            chk($sformatf("%s_busy%0d", tag, d), busy_w[d], 0);
            chk($sformatf("%s_done%0d", tag, d), done_w[d], 0);
            chk($sformatf("%s_pass%0d", tag, d), pass_w[d], 0);
            chk($sformatf("%s_err%0d", tag, d), err_w[d], 0);
            chk($sformatf("%s_fail%0d", tag, d), fail_w[d], 0);
            chk($sformatf("%s_vidx%0d", tag, d), vidx_w[d], 0);
        end
    endtask

    task automatic check_verdict(input string tag);
        int errs, first;
        expect_run(fault_mode, mask, errs, first);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_done%0d", tag, d), done_w[d], 1);
            chk($sformatf("%s_err%0d", tag, d), err_w[d], errs);
            chk($sformatf("%s_fail%0d", tag, d), fail_w[d], first);
            chk($sformatf("%s_pass%0d", tag, d), pass_w[d], (errs == 0) ? 1 : 0);
            chk($sformatf("%s_abc%0d", tag, d), {a_w[d], b_w[d], cin_w[d]}, 0);
        end
    endtask

    // Pulses start, measures start-to-done latency per instance, then checks the verdict.
    task automatic run(input string tag, input logic [1:0] m, input bit midstart);
        int lat [3];
        fault_mode = m;
        mask       = 8'($urandom);
        lat        = '{-1, -1, -1};
        @(negedge clk);
        start = 1'b1;
        for (int it = 1; it <= 200; it++) begin
            @(posedge clk);
            #1;
            if (it == 1) start = 1'b0;
            if (midstart && it == 10) start = 1'b1;
            if (midstart && it == 11) start = 1'b0;
            if (busy_w[0]) chk({tag, "_abc_vs_idx"}, {a_w[0], b_w[0], cin_w[0]}, vidx_w[0]);
            for (int d = 0; d < 3; d++) begin
                if (!done_w[d]) chk($sformatf("%s_pass_low%0d", tag, d), pass_w[d], 0);
                if (done_w[d] && lat[d] < 0) lat[d] = it - 1;
            end
            if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
        end
        for (int d = 0; d < 3; d++)
            chk($sformatf("%s_lat%0d", tag, d), lat[d], 8 * (2 + settle_of(d)));
        check_verdict(tag);
    endtask

    initial begin
        bit saw_done;
        bit hit;
        rst_n      = 1'b0;
        start      = 1'b0;
        fault_mode = 2'd0;
        mask       = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run("clean", 2'd0, 1'b0);
        run("cout_stuck", 2'd1, 1'b1);
        run("s_inv", 2'd2, 1'b0);

        // Start held in DONE restarts immediately with cleared counters.
        fault_mode = 2'd0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("restart_done%0d", d), done_w[d], 0);
            chk($sformatf("restart_busy%0d", d), busy_w[d], 1);
            chk($sformatf("restart_err%0d", d), err_w[d], 0);
            chk($sformatf("restart_vidx%0d", d), vidx_w[d], 0);
        end
        start = 1'b0;
        for (int it = 0; it < 200 && !(&done_w); it++) @(posedge clk);
        #1;
        check_verdict("restart");

        for (int r = 0; r < 4; r++) run($sformatf("rand%0d", r), 2'd3, r[0]);

        // Reset in the middle of a run (instance 0 at vector 4) aborts it silently.
        fault_mode = 2'd0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        hit = 1'b0;
        for (int it = 0; it < 100; it++) begin
            @(posedge clk);
            #1;
            if (vidx_w[0] == 3'd4) begin hit = 1'b1; break; end
        end
        chk("abort_reach_vec4", hit, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_idle_all("abort");
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (|done_w) saw_done = 1'b1;
        end
        chk("abort_no_done", saw_done, 0);
        run("after_abort", 2'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
